// File: rtl/countdown_ctrl_if.sv
// Handshake bundle between the countdown controller and its BCD digit chain / operator inputs.
// The master side drives requests and chain status; the slave (controller) drives strobes and status.
interface countdown_ctrl_if;
   logic       start;
   logic       stop;
   logic       load_req;
   logic       chain_zero;
   logic       digit_err;
   logic       ce;
   logic       load;
   logic       alarm;
   logic       busy;
   logic [1:0] state;

   modport master (
      output start, stop, load_req, chain_zero, digit_err,
      input  ce, load, alarm, busy, state
   );

   modport slave (
      input  start, stop, load_req, chain_zero, digit_err,
      output ce, load, alarm, busy, state
   );
endinterface

// File: rtl/countdown_ctrl.sv
// Countdown timer control: prescales clk into a ce tick for a BCD down-counter chain, stops the
// chain at zero, issues load strobes and holds a timed alarm.
module countdown_ctrl #(
   parameter int unsigned TICK_DIV    = 100000000,
   parameter int unsigned ALARM_TICKS = 5
) (
   input  logic              clk,
   input  logic              reset,
   countdown_ctrl_if.slave   bus
);

   localparam int unsigned CntW  = $clog2(TICK_DIV);
   localparam int unsigned AcntW = $clog2(ALARM_TICKS) + 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StAlarm = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [AcntW-1:0]  acnt_q, acnt_d;
   logic              ce_q, ce_d;
   logic              load_q, load_d;
   logic              alarm_q, alarm_d;
   logic              busy_q, busy_d;
   logic              cnt_wrap;

   assign cnt_wrap = (cnt_q == CntW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acnt_q  <= '0;
         ce_q    <= 1'b0;
         load_q  <= 1'b0;
         alarm_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acnt_q  <= acnt_d;
         ce_q    <= ce_d;
         load_q  <= load_d;
         alarm_q <= alarm_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acnt_d  = acnt_q;
      ce_d    = 1'b0;
      load_d  = 1'b0;
      if (bus.digit_err) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               load_d = bus.load_req;
               if (bus.start && !bus.stop && !bus.chain_zero) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end
            end
            StRun: begin
               if (bus.stop) begin
                  state_d = StPause;
               end else if (bus.chain_zero) begin
                  // Leave before the next tick so the chain never wraps to 9.
                  state_d = StAlarm;
                  cnt_d   = '0;
                  acnt_d  = '0;
               end else if (cnt_wrap) begin
                  cnt_d = '0;
                  ce_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StPause: begin
               if (bus.stop) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (bus.load_req) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  load_d  = 1'b1;
               end else if (bus.start) begin
                  state_d = StRun;
               end
            end
            StAlarm: begin
               if (bus.start || bus.stop) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  acnt_d  = '0;
               end else if (cnt_wrap) begin
                  cnt_d = '0;
                  if (acnt_q == AcntW'(ALARM_TICKS - 1)) begin
                     state_d = StIdle;
                     acnt_d  = '0;
                  end else begin
                     acnt_d = acnt_q + AcntW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
               acnt_d  = '0;
            end
         endcase
      end
   end

   // Status flags are registered alongside the state they describe.
   always_comb begin
      alarm_d = (state_d == StAlarm);
      busy_d  = (state_d == StRun) || (state_d == StPause);
   end

   assign bus.state = state_q;
   assign bus.ce    = ce_q;
   assign bus.load  = load_q;
   assign bus.alarm = alarm_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=4, ALARM_TICKS=2; inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point.
module tb_countdown_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   countdown_ctrl_if bus ();

   countdown_ctrl #(
      .TICK_DIV    (4),
      .ALARM_TICKS (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // ce must stay low for n-1 edges and be high after the n-th.
   task automatic expect_ce(input string tag, input int n);
      for (int i = 1; i < n; i++) begin
         step();
         chk({tag, "_ce_low"}, {31'd0, bus.ce}, 32'd0);
      end
      step();
      chk({tag, "_ce_high"}, {31'd0, bus.ce}, 32'd1);
   endtask

   task automatic all_idle(input string tag);
      chk({tag, "_state"}, {30'd0, bus.state}, 32'd0);
      chk({tag, "_ce"}, {31'd0, bus.ce}, 32'd0);
      chk({tag, "_load"}, {31'd0, bus.load}, 32'd0);
      chk({tag, "_alarm"}, {31'd0, bus.alarm}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.load_req   = 1'b0;
      bus.chain_zero = 1'b0;
      bus.digit_err  = 1'b0;
      step();
      step();
      all_idle("reset");
      reset = 1'b0;

      // Load strobe in IDLE
      bus.load_req = 1'b1;
      step();
      chk("load_pulse", {31'd0, bus.load}, 32'd1);
      chk("load_state", {30'd0, bus.state}, 32'd0);
      bus.load_req = 1'b0;
      step();
      chk("load_end", {31'd0, bus.load}, 32'd0);

      // Start and three ticks
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("run_state", {30'd0, bus.state}, 32'd1);
      chk("run_busy", {31'd0, bus.busy}, 32'd1);
      chk("run_ce0", {31'd0, bus.ce}, 32'd0);
      expect_ce("tick1", 4);
      expect_ce("tick2", 4);
      expect_ce("tick3", 4);

      // Chain reaches zero one cycle after the ce
      step();
      chk("post_tick_ce", {31'd0, bus.ce}, 32'd0);
      bus.chain_zero = 1'b1;
      step();
      chk("alarm_state", {30'd0, bus.state}, 32'd3);
      chk("alarm_busy", {31'd0, bus.busy}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         chk("alarm_hold", {31'd0, bus.alarm}, 32'd1);
         chk("alarm_no_ce", {31'd0, bus.ce}, 32'd0);
         step();
      end
      chk("alarm_last", {31'd0, bus.alarm}, 32'd1);
      step();
      chk("alarm_exit_state", {30'd0, bus.state}, 32'd0);
      chk("alarm_exit_alarm", {31'd0, bus.alarm}, 32'd0);
      bus.chain_zero = 1'b0;

      // Pause at cnt=2 and resume
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("pause_state", {30'd0, bus.state}, 32'd2);
      chk("pause_busy", {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("pause_no_ce", {31'd0, bus.ce}, 32'd0);
      end
      chk("pause_held", {30'd0, bus.state}, 32'd2);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("resume_state", {30'd0, bus.state}, 32'd1);
      expect_ce("resume", 2);
      bus.stop = 1'b1;
      step();
      chk("stop1_state", {30'd0, bus.state}, 32'd2);
      step();
      bus.stop = 1'b0;
      chk("stop2_state", {30'd0, bus.state}, 32'd0);
      chk("stop2_busy", {31'd0, bus.busy}, 32'd0);

      // start and stop together
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      chk("both_idle", {30'd0, bus.state}, 32'd0);
      bus.stop = 1'b0;
      step();
      chk("both_run_entry", {30'd0, bus.state}, 32'd1);
      bus.stop = 1'b1;
      step();
      chk("both_run", {30'd0, bus.state}, 32'd2);
      bus.start = 1'b0;
      step();
      chk("both_pause_stop", {30'd0, bus.state}, 32'd0);
      bus.stop  = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start      = 1'b0;
      bus.chain_zero = 1'b1;
      step();
      bus.chain_zero = 1'b0;
      chk("both_alarm_entry", {30'd0, bus.state}, 32'd3);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("both_alarm", {30'd0, bus.state}, 32'd0);
      chk("both_alarm_flag", {31'd0, bus.alarm}, 32'd0);

      // start ignored at zero
      bus.chain_zero = 1'b1;
      bus.start      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("zero_start_state", {30'd0, bus.state}, 32'd0);
         chk("zero_start_ce", {31'd0, bus.ce}, 32'd0);
      end
      bus.chain_zero = 1'b0;
      bus.start      = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      bus.digit_err = 1'b1;
      step();
      all_idle("err_run");
      bus.load_req = 1'b1;
      step();
      chk("err_idle_load", {31'd0, bus.load}, 32'd0);
      bus.digit_err = 1'b0;
      bus.load_req  = 1'b0;
      step();

      // Reset mid-RUN, on the edge that would have produced ce
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      all_idle("rst_run");
      reset = 1'b0;

      // Reset mid-ALARM
      bus.start = 1'b1;
      step();
      bus.start      = 1'b0;
      bus.chain_zero = 1'b1;
      step();
      bus.chain_zero = 1'b0;
      chk("rst_alarm_entry", {30'd0, bus.state}, 32'd3);
      step();
      reset = 1'b1;
      step();
      all_idle("rst_alarm");
      reset = 1'b0;

      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("post_rst_state", {30'd0, bus.state}, 32'd1);
      expect_ce("post_rst", 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
